// File: rtl/shift_add_mult_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl_if
// Description : Bundles the start/ready/done handshake, the operand and
//               product buses, and the external-adder connection of the
//               shift-and-add multiplier controller.
//               slave  : the controller side.
//               master : the requester side, which also owns the CLA.
//   start        requester -> ctrl  request, sampled only while ready=1
//   multiplicand requester -> ctrl  operand X
//   multiplier   requester -> ctrl  operand Y
//   ready        ctrl -> requester  controller idle
//   done         ctrl -> requester  one-cycle completion pulse
//   product      ctrl -> requester  registered 2*WIDTH result
//   add_a/add_b  ctrl -> CLA        adder operands
//   add_sum      CLA  -> ctrl       combinational add_a + add_b
// Revision    : 1.0  initial release
// ============================================================================
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 ready;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   add_a;
    logic [2*WIDTH-1:0]   add_b;
    logic [2*WIDTH-1:0]   add_sum;

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        input  add_sum,
        output ready,
        output done,
        output product,
        output add_a,
        output add_b
    );

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        output add_sum,
        input  ready,
        input  done,
        input  product,
        input  add_a,
        input  add_b
    );
endinterface
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Sequential unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add
//               multiplier controller. The only adder is an external
//               combinational 2*WIDTH-bit CLA: each RUN cycle this block
//               presents the accumulator on add_a and either the shifted
//               multiplicand or zero on add_b, and captures add_sum.
// Ports       : clk  rising-edge clock
//               rst  asynchronous active-high reset
//               bus  shift_add_mult_ctrl_if.slave (handshake, operands,
//                    product, adder A/B/SUM)
// Timing      : accept edge E0 -> WIDTH RUN cycles -> done high in the
//               cycle after edge E0+WIDTH -> ready again one cycle later.
// Revision    : 1.0  initial release
// ============================================================================
module shift_add_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    shift_add_mult_ctrl_if.slave      bus
);

    localparam int c_prod_w = 2 * WIDTH;
    localparam int c_cnt_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_prod_w-1:0]  r_acc;
    logic [c_prod_w-1:0]  r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_prod_w-1:0]  r_product;

    logic                 w_in_run;
    logic                 w_last;
    logic                 w_accept;

    assign w_in_run = (r_state == ST_RUN);
    assign w_last   = (r_count == c_last_cnt);
    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            // Operands are sampled only here; later changes on the bus,
            // and starts seen while busy, never reach the datapath.
            r_mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
            r_mplier <= bus.multiplier;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_in_run) begin
            r_acc    <= bus.add_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            // Wrap to zero explicitly so the counter stays within
            // 0..WIDTH-1 even when WIDTH is not a power of two.
            r_count  <= w_last ? '0 : r_count + 1'b1;
            if (w_last) begin
                // The final partial sum is taken straight from the adder so
                // the product is valid in the first DONE cycle.
                r_product <= bus.add_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The adder inputs are forced to zero outside RUN so the CLA
    // sees no activity while idle.
    // ------------------------------------------------------------------
    assign bus.ready   = (r_state == ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.product = r_product;
    assign bus.add_a   = w_in_run ? r_acc : '0;
    assign bus.add_b   = (w_in_run && r_mplier[0]) ? r_mcand : '0;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult_ctrl
// Description : Self-checking bench for shift_add_mult_ctrl. The bench
//               stands in for the external 64-bit CLA with a continuous
//               add. Table-driven multiplies with hand-computed products,
//               plus hand-written busy-rejection and mid-RUN reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_add_mult_ctrl;

    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    shift_add_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

    // Behavioural stand-in for the external carry-lookahead adder.
    assign bus.add_sum = bus.add_a + bus.add_b;

    shift_add_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] exp;
        string       tag;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // One complete multiply: accept, WIDTH RUN cycles with the adder
    // operands tracked against an expected accumulator, DONE, back to IDLE.
    task automatic run_mult(input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp, input string tag);
        int          waited;
        logic [63:0] acc;
        logic [63:0] mc;
        logic [63:0] eb;
        logic [31:0] mp;
        waited = 0;
        while (bus.ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " ready_before_start"}, 64'(bus.ready), 64'd1);
        bus.start        = 1'b1;
        bus.multiplicand = x;
        bus.multiplier   = y;
        @(posedge clk); #1;
        // Scramble the operand inputs; the captured copies must be used.
        bus.start        = 1'b0;
        bus.multiplicand = ~x;
        bus.multiplier   = ~y;
        acc = '0;
        mc  = {32'b0, x};
        mp  = y;
        for (int k = 0; k < WIDTH; k++) begin
            eb = mp[0] ? mc : 64'd0;
            check({tag, " run_ready"}, 64'(bus.ready), 64'd0);
            check({tag, " run_done"},  64'(bus.done),  64'd0);
            check({tag, " run_add_a"}, bus.add_a, acc);
            check({tag, " run_add_b"}, bus.add_b, eb);
            acc = acc + eb;
            mc  = mc << 1;
            mp  = mp >> 1;
            @(posedge clk); #1;
        end
        // Cycle following edge E0+WIDTH.
        check({tag, " done_pulse"},   64'(bus.done),  64'd1);
        check({tag, " done_product"}, bus.product,    exp);
        check({tag, " done_ready"},   64'(bus.ready), 64'd0);
        check({tag, " done_add_a"},   bus.add_a,      64'd0);
        check({tag, " done_add_b"},   bus.add_b,      64'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(bus.done),  64'd0);
        check({tag, " ready_back"},     64'(bus.ready), 64'd1);
        check({tag, " product_hold"},   bus.product,    exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        checks   = 0;
        failures = 0;

        vecs[0] = '{32'h00000003, 32'h00000005, 64'h000000000000000F, "v3x5"};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "vmaxsq"};
        vecs[2] = '{32'h00000170, 32'h00000608, 64'h000000000008AB80, "v170x608"};
        vecs[3] = '{32'h00000101, 32'h00000002, 64'h0000000000000202, "v101x2"};
        vecs[4] = '{32'h12345678, 32'h00000000, 64'h0000000000000000, "vzero_y"};
        vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000, "vzero_x"};
        vecs[6] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, "vmsb"};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, "vmaxx1"};

        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #1;
        check("reset ready",   64'(bus.ready), 64'd1);
        check("reset done",    64'(bus.done),  64'd0);
        check("reset product", bus.product,    64'd0);
        check("reset add_a",   bus.add_a,      64'd0);
        check("reset add_b",   bus.add_b,      64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Consecutive calls start the next multiply in the first ready cycle.
        for (int i = 0; i < 8; i++) begin
            run_mult(vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].tag);
        end

        // Busy rejection: start held high with different operands through
        // RUN and DONE.
        bus.start        = 1'b1;
        bus.multiplicand = 32'h00000170;
        bus.multiplier   = 32'h00000608;
        @(posedge clk); #1;
        bus.multiplicand = 32'hDEADBEEF;
        bus.multiplier   = 32'hCAFEF00D;
        ndone = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        check("busy done_pulse",   64'(bus.done), 64'd1);
        check("busy done_product", bus.product,   64'h000000000008AB80);
        ndone++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy ready_back",   64'(bus.ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("busy single_done",   64'(ndone),     64'd1);
        check("busy product_stays", bus.product,    64'h000000000008AB80);
        check("busy still_idle",    64'(bus.ready), 64'd1);

        // Asynchronous reset in the middle of RUN cycle 10.
        bus.start        = 1'b1;
        bus.multiplicand = 32'h00000003;
        bus.multiplier   = 32'h00000005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("pre_reset busy", 64'(bus.ready), 64'd0);
        rst = 1'b1;
        #1;
        check("async_rst ready",   64'(bus.ready), 64'd1);
        check("async_rst product", bus.product,    64'd0);
        check("async_rst add_a",   bus.add_a,      64'd0);
        check("async_rst add_b",   bus.add_b,      64'd0);
        check("async_rst done",    64'(bus.done),  64'd0);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("aborted no_done", 64'(ndone), 64'd0);
        run_mult(32'h00000101, 32'h00000002, 64'h0000000000000202, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
